// File: rtl/sram_stream_pkg.sv
// Shared types and helpers for the SRAM sample streamer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, strobe polarity constants, WAIT counter width.
package sram_stream_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_LATCH = 3'd3,
      ST_DONE  = 3'd4
   } stream_state_e;

   // SRAM strobes are active-low.
   localparam logic STROBE_ACTIVE = 1'b0;
   localparam logic STROBE_IDLE   = 1'b1;

   // Width of a counter that must hold values 0..wait_cyc.
   function automatic int wait_cnt_w(input int wait_cyc);
      return (wait_cyc < 2) ? 1 : $clog2(wait_cyc + 1);
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding fetched samples for the codec side.
// Latency: a push is visible at the head (pop_data/empty) the cycle after the write edge.
// Backpressure: full reported to the writer; push while full is dropped unless a pop frees the slot.
//
// Ports: Clk, reset (sync, active-high), push/push_data, pop, flush (empties in one cycle),
//        pop_data (head, registered storage, 0 when empty), full, empty, count.
module sample_fifo #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            Clk,
   input  logic                            reset,
   input  logic                            push,
   input  logic [DATA_W-1:0]               push_data,
   input  logic                            pop,
   input  logic                            flush,
   output logic [DATA_W-1:0]               pop_data,
   output logic                            full,
   output logic                            empty,
   output logic [$clog2(FIFO_DEPTH):0]     count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  cnt;
   logic              do_push;
   logic              do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CNT_W'(FIFO_DEPTH));
   assign count   = cnt;
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot a full-FIFO push would need.
   assign do_push = push && (!full || do_pop);

   // Head comes straight from storage registers; forced to 0 when empty.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge Clk) begin
      if (do_push && !reset && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/sram_sample_streamer.sv
// SRAM playback engine: reads a block of samples with WAIT_CYC wait states into an output FIFO.
// Latency: start -> first sample_valid after WAIT_CYC+3 cycles; one sample per WAIT_CYC+2 cycles sustained.
// Backpressure: sample_valid/sample_ready; fetching pauses (OE_N high) while the FIFO is full.
//
// Ports: Clk, reset (sync, active-high), start (pulse, idle only), stop (abort+flush, any state),
//        base_addr/num_samples (latched on start), SRAM_* strobes/address/data,
//        sample_data/sample_valid/sample_ready (FIFO head), busy, done (1-cycle pulse).
// Optional: define SRAM_STREAM_LOOP_EN to add input loop and output wrapped (block replays forever).
module sram_sample_streamer
   import sram_stream_pkg::*;
#(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 16,
   parameter int WAIT_CYC   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
`ifdef SRAM_STREAM_LOOP_EN
   input  logic              loop,
   output logic              wrapped,
`endif
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_samples,
   output logic              SRAM_CE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   input  logic [DATA_W-1:0] SRAM_DQ,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] IDLE  = 3'(ST_IDLE);
   localparam logic [2:0] ADDR  = 3'(ST_ADDR);
   localparam logic [2:0] WAIT  = 3'(ST_WAIT);
   localparam logic [2:0] LATCH = 3'(ST_LATCH);
   localparam logic [2:0] DONE  = 3'(ST_DONE);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int WC_W  = wait_cnt_w(WAIT_CYC);
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_CYC - 1);

   logic [2:0]        state;
   // Set while parked in IDLE waiting for FIFO space (initial start or mid-block hold).
   logic              pend;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] remaining;
   logic [ADDR_W-1:0] base_lat;
   logic [ADDR_W-1:0] len_lat;
   logic [WC_W-1:0]   wait_cnt;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              fetching;
   logic              last_word;
   logic              latch_space;
   logic              reload;

`ifdef SRAM_STREAM_LOOP_EN
   assign reload = loop;
`else
   assign reload = 1'b0;
`endif

   assign fetching  = (state == ADDR) || (state == WAIT) || (state == LATCH);
   assign last_word = (remaining == ADDR_W'(1));

   assign fifo_push = (state == LATCH);
   assign fifo_pop  = sample_valid && sample_ready;

   // Room for another fetch once this LATCH write and any same-cycle pop settle.
   // count >= pop here, so the subtraction cannot underflow.
   assign latch_space = (fifo_count - CNT_W'(fifo_pop)) < CNT_W'(FIFO_DEPTH - 1);

   always_ff @(posedge Clk) begin
      if (reset) begin
         state     <= IDLE;
         pend      <= 1'b0;
         cur_addr  <= '0;
         remaining <= '0;
         base_lat  <= '0;
         len_lat   <= '0;
         wait_cnt  <= '0;
      end else if (stop) begin
         state <= IDLE;
         pend  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pend) begin
                  if (!fifo_full) begin
                     state <= ADDR;
                     pend  <= 1'b0;
                  end
               end else if (start) begin
                  cur_addr  <= base_addr;
                  remaining <= num_samples;
                  base_lat  <= base_addr;
                  len_lat   <= num_samples;
                  if (num_samples == '0) begin
                     state <= DONE;
                  end else if (!fifo_full) begin
                     state <= ADDR;
                  end else begin
                     pend <= 1'b1;
                  end
               end
            end
            ADDR: begin
               state    <= WAIT;
               wait_cnt <= '0;
            end
            WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state <= LATCH;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            LATCH: begin
               if (last_word && !reload) begin
                  cur_addr  <= cur_addr + 1'b1;
                  remaining <= '0;
                  state     <= DONE;
               end else begin
                  if (last_word) begin
                     cur_addr  <= base_lat;
                     remaining <= len_lat;
                  end else begin
                     cur_addr  <= cur_addr + 1'b1;
                     remaining <= remaining - 1'b1;
                  end
                  if (latch_space) begin
                     state <= ADDR;
                  end else begin
                     state <= IDLE;
                     pend  <= 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SRAM_STREAM_LOOP_EN
   logic wrap_pulse;

   always_ff @(posedge Clk) begin
      if (reset || stop) begin
         wrap_pulse <= 1'b0;
      end else begin
         wrap_pulse <= (state == LATCH) && last_word && loop;
      end
   end

   assign wrapped = wrap_pulse;
`endif

   sample_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clk       (Clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (SRAM_DQ),
      .pop       (fifo_pop),
      .flush     (stop),
      .pop_data  (sample_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign sample_valid = !fifo_empty;
   assign busy         = (state != IDLE) || pend;
   assign done         = (state == DONE);

   assign SRAM_ADDR = cur_addr;
   assign SRAM_OE_N = fetching ? STROBE_ACTIVE : STROBE_IDLE;
   assign SRAM_CE_N = busy ? STROBE_ACTIVE : STROBE_IDLE;
   assign SRAM_WE_N = STROBE_IDLE;
   assign SRAM_UB_N = STROBE_ACTIVE;
   assign SRAM_LB_N = STROBE_ACTIVE;

endmodule

// File: tb/tb_sram_sample_streamer.sv
// Directed bench for sram_sample_streamer with default parameters (WAIT_CYC=2, FIFO_DEPTH=4).
// Cycle c is observed at the falling edge after rising edge c-1; start is sampled at edge 0.
// SRAM model returns addr[15:0] ^ 16'hA5A5 while OE_N is low.
module tb_sram_sample_streamer;

   logic        Clk = 1'b0;
   logic        reset;
   logic        start;
   logic        stop;
   logic [19:0] base_addr;
   logic [19:0] num_samples;
   logic        SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;
   logic [19:0] SRAM_ADDR;
   logic [15:0] SRAM_DQ;
   logic [15:0] sample_data;
   logic        sample_valid;
   logic        sample_ready;
   logic        busy;
   logic        done;
`ifdef SRAM_STREAM_LOOP_EN
   logic        loop;
   logic        wrapped;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 Clk = ~Clk;

   assign SRAM_DQ = SRAM_OE_N ? 16'hDEAD : (SRAM_ADDR[15:0] ^ 16'hA5A5);

   sram_sample_streamer dut (
      .Clk          (Clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
`ifdef SRAM_STREAM_LOOP_EN
      .loop         (loop),
      .wrapped      (wrapped),
`endif
      .base_addr    (base_addr),
      .num_samples  (num_samples),
      .SRAM_CE_N    (SRAM_CE_N),
      .SRAM_UB_N    (SRAM_UB_N),
      .SRAM_LB_N    (SRAM_LB_N),
      .SRAM_OE_N    (SRAM_OE_N),
      .SRAM_WE_N    (SRAM_WE_N),
      .SRAM_ADDR    (SRAM_ADDR),
      .SRAM_DQ      (SRAM_DQ),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .busy         (busy),
      .done         (done)
   );

   task automatic apply_reset();
      @(negedge Clk);
      reset = 1'b1; start = 1'b0; stop = 1'b0; sample_ready = 1'b0;
      base_addr = '0; num_samples = '0;
`ifdef SRAM_STREAM_LOOP_EN
      loop = 1'b0;
`endif
      repeat (2) @(negedge Clk);
      reset = 1'b0;
   endtask

   // Returns at the falling edge of cycle 1.
   task automatic kick(input logic [19:0] b, input logic [19:0] n);
      base_addr = b; num_samples = n; start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      tests_run++;
      if ({busy, done, sample_valid} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_flags: busy/done/valid=%b expected 000", {busy, done, sample_valid});
      end
      tests_run++;
      if (sample_data !== 16'h0000 || SRAM_ADDR !== 20'h0) begin
         tests_failed++;
         $display("FAIL reset_data: data=%h addr=%h expected 0000/00000", sample_data, SRAM_ADDR);
      end
      tests_run++;
      if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11100) begin
         tests_failed++;
         $display("FAIL reset_strobes: CE/OE/WE/UB/LB=%b expected 11100",
                  {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N});
      end
   endtask

   task automatic test_basic();
      logic [15:0] got [$];
      logic [15:0] exp_d [3] = '{16'hA5B5, 16'hA5B4, 16'hA5B7};
      int first_valid = -1;
      int done_cyc    = -1;
      int done_cnt    = 0;
      apply_reset();
      sample_ready = 1'b1;
      kick(20'h00010, 20'd3);
      for (int c = 1; c <= 20; c++) begin
         if (c == 1) begin
            tests_run++;
            if (SRAM_OE_N !== 1'b0 || SRAM_ADDR !== 20'h00010 || SRAM_CE_N !== 1'b0) begin
               tests_failed++;
               $display("FAIL basic_addr_phase: OE_N=%b CE_N=%b addr=%h expected 0/0/00010",
                        SRAM_OE_N, SRAM_CE_N, SRAM_ADDR);
            end
         end
         if (sample_valid && first_valid < 0) first_valid = c;
         if (sample_valid && sample_ready) got.push_back(sample_data);
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         @(negedge Clk);
      end
      tests_run++;
      if (first_valid != 5) begin
         tests_failed++;
         $display("FAIL basic_first_valid: cycle %0d expected 5", first_valid);
      end
      tests_run++;
      if (done_cyc != 13 || done_cnt != 1) begin
         tests_failed++;
         $display("FAIL basic_done: cycle %0d count %0d expected cycle 13 count 1", done_cyc, done_cnt);
      end
      tests_run++;
      if (got.size() != 3) begin
         tests_failed++;
         $display("FAIL basic_count: %0d samples expected 3", got.size());
      end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         tests_run++;
         if (got[i] !== exp_d[i]) begin
            tests_failed++;
            $display("FAIL basic_sample%0d: got %h expected %h", i, got[i], exp_d[i]);
         end
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] got [$];
      int oe_low   = 0;
      int done_cnt = 0;
      apply_reset();
      kick(20'h00020, 20'd8);
      for (int c = 1; c <= 40; c++) begin
         if (SRAM_OE_N === 1'b0) oe_low++;
         if (done) done_cnt++;
         @(negedge Clk);
      end
      // Four fetches of WAIT_CYC+2 = 4 cycles each, then parked.
      tests_run++;
      if (oe_low != 16) begin
         tests_failed++;
         $display("FAIL bp_read_cycles: OE_N low %0d cycles expected 16", oe_low);
      end
      tests_run++;
      if (SRAM_OE_N !== 1'b1 || busy !== 1'b1 || sample_valid !== 1'b1 || done_cnt != 0) begin
         tests_failed++;
         $display("FAIL bp_hold: OE_N=%b busy=%b valid=%b done_cnt=%0d expected 1/1/1/0",
                  SRAM_OE_N, busy, sample_valid, done_cnt);
      end
      sample_ready = 1'b1;
      for (int c = 0; c < 80; c++) begin
         if (sample_valid && sample_ready) got.push_back(sample_data);
         if (done) done_cnt++;
         @(negedge Clk);
      end
      tests_run++;
      if (got.size() != 8 || done_cnt != 1) begin
         tests_failed++;
         $display("FAIL bp_drain: %0d samples done_cnt=%0d expected 8 and 1", got.size(), done_cnt);
      end
      for (int i = 0; i < got.size() && i < 8; i++) begin
         logic [15:0] e;
         e = 16'h0020 + 16'(i);
         e = e ^ 16'hA5A5;
         tests_run++;
         if (got[i] !== e) begin
            tests_failed++;
            $display("FAIL bp_sample%0d: got %h expected %h", i, got[i], e);
         end
      end
   endtask

   task automatic test_zero_len();
      int oe_low   = 0;
      int vld_cnt  = 0;
      int done_cnt = 0;
      apply_reset();
      sample_ready = 1'b1;
      kick(20'h00123, 20'd0);
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++;
         $display("FAIL zero_done_cycle1: done=%b expected 1", done);
      end
      for (int c = 1; c <= 8; c++) begin
         if (SRAM_OE_N === 1'b0) oe_low++;
         if (sample_valid) vld_cnt++;
         if (done) done_cnt++;
         @(negedge Clk);
      end
      tests_run++;
      if (oe_low != 0 || vld_cnt != 0 || done_cnt != 1) begin
         tests_failed++;
         $display("FAIL zero_len: oe_low=%0d valid=%0d done=%0d expected 0/0/1", oe_low, vld_cnt, done_cnt);
      end
   endtask

   task automatic test_wrap();
      logic [19:0] exp_a [4] = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
      logic [15:0] exp_d [4] = '{16'h5A5B, 16'h5A5A, 16'hA5A5, 16'hA5A4};
      logic [15:0] got [$];
      apply_reset();
      sample_ready = 1'b1;
      kick(20'hFFFFE, 20'd4);
      for (int c = 1; c <= 24; c++) begin
         if (c % 4 == 1 && c <= 13) begin
            tests_run++;
            if (SRAM_ADDR !== exp_a[(c - 1) / 4] || SRAM_OE_N !== 1'b0) begin
               tests_failed++;
               $display("FAIL wrap_addr%0d: addr=%h OE_N=%b expected %h/0",
                        (c - 1) / 4, SRAM_ADDR, SRAM_OE_N, exp_a[(c - 1) / 4]);
            end
         end
         if (sample_valid && sample_ready) got.push_back(sample_data);
         @(negedge Clk);
      end
      tests_run++;
      if (got.size() != 4) begin
         tests_failed++;
         $display("FAIL wrap_count: %0d samples expected 4", got.size());
      end
      for (int i = 0; i < got.size() && i < 4; i++) begin
         tests_run++;
         if (got[i] !== exp_d[i]) begin
            tests_failed++;
            $display("FAIL wrap_sample%0d: got %h expected %h", i, got[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_stop();
      int done_cnt = 0;
      logic [15:0] got [$];
      apply_reset();
      kick(20'h00040, 20'd8);
      // Latches at cycles 4 and 8; cycle 10 is the first WAIT of the third fetch.
      repeat (9) @(negedge Clk);
      tests_run++;
      if (sample_valid !== 1'b1 || SRAM_OE_N !== 1'b0 || SRAM_ADDR !== 20'h00042) begin
         tests_failed++;
         $display("FAIL stop_pre: valid=%b OE_N=%b addr=%h expected 1/0/00042",
                  sample_valid, SRAM_OE_N, SRAM_ADDR);
      end
      stop = 1'b1;
      @(negedge Clk);
      stop = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || sample_valid !== 1'b0 || SRAM_OE_N !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL stop_post: busy=%b valid=%b OE_N=%b done=%b expected 0/0/1/0",
                  busy, sample_valid, SRAM_OE_N, done);
      end
      for (int c = 0; c < 6; c++) begin
         if (done || busy) done_cnt++;
         @(negedge Clk);
      end
      tests_run++;
      if (done_cnt != 0) begin
         tests_failed++;
         $display("FAIL stop_quiet: %0d cycles with done/busy expected 0", done_cnt);
      end
      // stop and start together: stop wins.
      base_addr = 20'h00060; num_samples = 20'd2; start = 1'b1; stop = 1'b1;
      @(negedge Clk);
      start = 1'b0; stop = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || SRAM_OE_N !== 1'b1) begin
         tests_failed++;
         $display("FAIL stop_beats_start: busy=%b OE_N=%b expected 0/1", busy, SRAM_OE_N);
      end
      sample_ready = 1'b1;
      kick(20'h00080, 20'd1);
      tests_run++;
      if (SRAM_ADDR !== 20'h00080 || SRAM_OE_N !== 1'b0) begin
         tests_failed++;
         $display("FAIL restart_addr: addr=%h OE_N=%b expected 00080/0", SRAM_ADDR, SRAM_OE_N);
      end
      for (int c = 1; c <= 10; c++) begin
         if (sample_valid && sample_ready) got.push_back(sample_data);
         @(negedge Clk);
      end
      tests_run++;
      if (got.size() != 1 || (got.size() == 1 && got[0] !== 16'hA525)) begin
         tests_failed++;
         $display("FAIL restart_data: %0d samples first=%h expected 1 sample A525",
                  got.size(), (got.size() > 0) ? got[0] : 16'h0);
      end
   endtask

`ifdef SRAM_STREAM_LOOP_EN
   task automatic test_loop();
      logic [19:0] exp_a [4] = '{20'h00100, 20'h00101, 20'h00100, 20'h00101};
      int wrap_cnt = 0;
      int done_cnt = 0;
      int wrap_c0  = -1;
      apply_reset();
      sample_ready = 1'b1;
      loop = 1'b1;
      kick(20'h00100, 20'd2);
      for (int c = 1; c <= 20; c++) begin
         if (c % 4 == 1 && c <= 13) begin
            tests_run++;
            if (SRAM_ADDR !== exp_a[(c - 1) / 4]) begin
               tests_failed++;
               $display("FAIL loop_addr%0d: addr=%h expected %h", (c - 1) / 4, SRAM_ADDR, exp_a[(c - 1) / 4]);
            end
         end
         if (wrapped) begin
            wrap_cnt++;
            if (wrap_c0 < 0) wrap_c0 = c;
         end
         if (done) done_cnt++;
         @(negedge Clk);
      end
      tests_run++;
      if (wrap_cnt != 2 || wrap_c0 != 9 || done_cnt != 0) begin
         tests_failed++;
         $display("FAIL loop_pulses: wrapped=%0d first=%0d done=%0d expected 2/9/0", wrap_cnt, wrap_c0, done_cnt);
      end
      stop = 1'b1;
      loop = 1'b0;
      @(negedge Clk);
      stop = 1'b0;
   endtask
`endif

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; sample_ready = 1'b0;
      base_addr = '0; num_samples = '0;
`ifdef SRAM_STREAM_LOOP_EN
      loop = 1'b0;
`endif
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_len();
      test_wrap();
      test_stop();
`ifdef SRAM_STREAM_LOOP_EN
      test_loop();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/sram_sample_streamer.md
# sram_sample_streamer

Parametrised SRAM playback engine for the audio path: on a start pulse it reads a contiguous block of samples from external SRAM with a configurable number of read wait states, and buffers them in a small output FIFO. The audio codec interface drains the FIFO through a valid/ready handshake. It replaces the single-step, press-per-sample SRAM reader. It adds programmable base and length, back-pressure, stop/flush and optional looping.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample width; equals SRAM data width
- WAIT_CYC, 2, cycles OE_N held low before data capture (≥1)
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2

Ports:
- Clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; honoured only in IDLE
- stop  in  1  abort and flush; honoured in any state
- base_addr  in  ADDR_W  first word address, latched on start
- num_samples  in  ADDR_W  words to read, latched on start
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N  out  1 each  SRAM strobes
- SRAM_ADDR  out  ADDR_W  SRAM word address
- SRAM_DQ  in  DATA_W  SRAM read data
- sample_data  out  DATA_W  FIFO head
- sample_valid  out  1  FIFO non-empty
- sample_ready  in  1  consumer accepts head
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at block end

## Operation
- States: IDLE, ADDR, WAIT, LATCH, DONE.
- IDLE. On start, latch cur_addr=base_addr and remaining=num_samples.
  - If num_samples==0, go to DONE.
  - Otherwise go to ADDR when FIFO count<FIFO_DEPTH, else stay in a fetch-pending sub-condition of IDLE with busy=1.
- ADDR (1 cycle). SRAM_ADDR=cur_addr, SRAM_OE_N=0, then go to WAIT.
- WAIT (WAIT_CYC cycles, internal counter). Address and OE_N held.
- LATCH (1 cycle). OE_N stays 0, SRAM_DQ is written into the FIFO at the clock edge, cur_addr+1 (wraps 2^ADDR_W-1→0), remaining−1.
  - If the new remaining≠0 and FIFO has space: ADDR.
  - If the new remaining≠0 and FIFO is full: HOLD condition, back-pressure wait, OE_N=1.
  - If the new remaining==0: DONE.
- DONE. done=1 for exactly one cycle, then IDLE. The FIFO keeps draining after DONE.
- Space check happens only when entering ADDR. Pops during a fetch can only free space, so a LATCH write never overflows.
- FIFO pop on sample_valid&&sample_ready. Simultaneous push and pop keeps count unchanged.
- stop: next state IDLE, FIFO flushed (count=0), no done pulse. stop wins over start in the same cycle.
- SRAM_WE_N=1 always; UB_N=LB_N=0 always; CE_N=0 while busy, else 1.
- Reset values: state IDLE, SRAM_ADDR=0, OE_N=1, CE_N=1, WE_N=1, UB_N=LB_N=0, sample_valid=0, sample_data=0, busy=0, done=0, FIFO empty. Reset mid-transfer behaves as stop plus register clear.

## Timing
- start sampled at edge 0 → ADDR in cycle 1, WAIT cycles 2..1+WAIT_CYC, LATCH in cycle 2+WAIT_CYC, sample_valid=1 in cycle 3+WAIT_CYC.
- Sustained throughput with no back-pressure: one sample per WAIT_CYC+2 cycles.
- done asserts the cycle after the final LATCH.
- sample_data is registered (FIFO head), with no combinational path from SRAM_DQ.

## Configuration
- SRAM_STREAM_LOOP_EN defined: adds input port loop (1 bit).
  - At remaining==0 with loop=1, cur_addr and remaining reload from the latched base/length and go straight to ADDR (or HOLD).
  - No done pulse fires; instead a wrapped output pulses for 1 cycle.
  - loop=0 behaves as the undefined case.
- Undefined: no loop or wrapped ports; a block always ends in DONE.

## Structure
- Package sram_stream_pkg: state enum type, WAIT-counter width function (clog2), strobe constants for active/idle.
- Sub-module sample_fifo (params DATA_W, FIFO_DEPTH; push, pop, flush, full, empty, count) instantiated once. FSM and address/length counters stay in sram_sample_streamer.

## Test plan
- Basic read, WAIT_CYC=2: base=0x00010, num=3, SRAM model returns addr^0xA5A5, ready=1 → samples 0xA5B5, 0xA5B4, 0xA5B7. First valid in cycle 5. done one cycle after the third LATCH.
- Back-pressure: num=8, ready=0 → exactly 4 LATCHes, then OE_N=1 and no further reads. Raise ready → remaining 4 delivered in order, no loss or duplication.
- Zero length: num=0 → done pulses in cycle 1, OE_N never low, sample_valid stays 0.
- Wrap: base=0xFFFFE, num=4 → addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Stop mid-WAIT with 2 entries buffered → IDLE next cycle, sample_valid=0, no done. A fresh start then reads from the new base.
- SRAM_STREAM_LOOP_EN, loop=1, base=0x100, num=2 → address sequence 0x100, 0x101, 0x100, 0x101…, wrapped pulses after each second LATCH, done never asserted.
